// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch front end. Issues sequential word fetches to an
//             in-order instruction memory, tags each request with its PC,
//             buffers returned instructions for decode and squashes in-flight
//             responses on an execute-stage redirect.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_PC   first fetch address after reset
//    DEPTH      outstanding requests + buffered entries limit (2..4)
//    NOP_INSTR  value presented on instr_f while valid_f=0
//  Ports
//    clk, reset                  clock, asynchronous active-high reset
//    stall_f                     decode not accepting the head entry
//    pc_src_e, pc_target_e       redirect strobe and target from execute
//    imem_req/addr/gnt           request channel (handshake = req & gnt)
//    imem_rvalid/rdata           in-order response channel
//    valid_f, instr_f, pc_f,
//    pc_plus4_f                  head of the fetch buffer towards decode
//    misalign_f                  last redirect target was misaligned
//  Configuration
//    FETCH_MISALIGN_TRAP_EN      when defined, a misaligned redirect target
//                                halts fetching and raises misalign_f; when
//                                undefined the target is forced word-aligned.
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_f,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        misalign_f
);

  localparam int               PTR_W       = (DEPTH > 2) ? 2 : 1;
  localparam int               CNT_W       = (DEPTH > 3) ? 3 : 2;
  localparam logic [CNT_W:0]   DEPTH_LIMIT = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(DEPTH - 1);

  // Circular pointer increment; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  logic [31:0]      fetch_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] drop_cnt;
  logic             halt;

  // PC tags of requests in flight (includes requests already marked for drop)
  logic [31:0]      tag_pc [DEPTH];
  logic [PTR_W-1:0] tag_wr;
  logic [PTR_W-1:0] tag_rd;

  // Fetch buffer towards decode
  logic [31:0]      buf_pc    [DEPTH];
  logic [31:0]      buf_instr [DEPTH];
  logic [PTR_W-1:0] buf_wr;
  logic [PTR_W-1:0] buf_rd;

  logic [31:0]      target_pc;
  logic             target_misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_pc         = pc_target_e;
  assign target_misaligned = |pc_target_e[1:0];
`else
  logic unused_target_bits;
  assign target_pc          = {pc_target_e[31:2], 2'b00};
  assign target_misaligned  = 1'b0;
  assign unused_target_bits = ^pc_target_e[1:0];
`endif

  logic             handshake;
  logic             resp;
  logic             resp_keep;
  logic             resp_drop;
  logic             pop;
  logic [CNT_W-1:0] outstanding_nxt;
  logic [CNT_W:0]   in_use;

  assign handshake = imem_req & imem_gnt;
  // A response with nothing outstanding is stray and must not touch counters.
  assign resp      = imem_rvalid & (outstanding != '0);
  assign resp_drop = resp & (drop_cnt != '0);
  assign resp_keep = resp & (drop_cnt == '0);
  assign pop       = valid_f & ~stall_f;

  assign outstanding_nxt = outstanding + CNT_W'(handshake) - CNT_W'(resp);
  assign in_use          = {1'b0, outstanding} + {1'b0, occupancy};

  // Dropped requests still occupy memory-side slots, so they count here too.
  assign imem_req  = ~reset & ~pc_src_e & ~halt & (in_use < DEPTH_LIMIT);
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      occupancy   <= '0;
      drop_cnt    <= '0;
      halt        <= 1'b0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (handshake) tag_wr <= ptr_inc(tag_wr);
      if (resp)      tag_rd <= ptr_inc(tag_rd);

      if (pc_src_e) begin
        // Redirect wins: flush the buffer and squash everything still in
        // flight after this cycle's response (if any) has been retired.
        fetch_pc  <= target_pc;
        halt      <= target_misaligned;
        drop_cnt  <= outstanding_nxt;
        occupancy <= '0;
        buf_wr    <= '0;
        buf_rd    <= '0;
      end else begin
        if (handshake) fetch_pc <= fetch_pc + 32'd4;
        if (resp_drop) drop_cnt <= drop_cnt - CNT_W'(1);
        if (resp_keep) buf_wr   <= ptr_inc(buf_wr);
        if (pop)       buf_rd   <= ptr_inc(buf_rd);
        occupancy <= occupancy + CNT_W'(resp_keep) - CNT_W'(pop);
      end
    end
  end

  // Storage needs no reset: occupancy and outstanding qualify every read.
  always_ff @(posedge clk) begin
    if (handshake) begin
      tag_pc[tag_wr] <= fetch_pc;
    end
    if (resp_keep && !pc_src_e) begin
      buf_pc[buf_wr]    <= tag_pc[tag_rd];
      buf_instr[buf_wr] <= imem_rdata;
    end
  end

  assign valid_f    = (occupancy != '0);
  assign instr_f    = valid_f ? buf_instr[buf_rd] : NOP_INSTR;
  assign pc_f       = valid_f ? buf_pc[buf_rd] : 32'h0000_0000;
  assign pc_plus4_f = pc_f + 32'd4;
  assign misalign_f = halt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. A memory model answers
//             granted requests in order with random latency; a reference
//             model of the fetch stream pushes expected {pc, instr} entries
//             into a scoreboard queue which a separate monitor pops against
//             the decode-side outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_f = 1'b0;
  logic        pc_src_e = 1'b0;
  logic [31:0] pc_target_e = '0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        valid_f;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        misalign_f;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall_f    (stall_f),
    .pc_src_e   (pc_src_e),
    .pc_target_e(pc_target_e),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .valid_f    (valid_f),
    .instr_f    (instr_f),
    .pc_f       (pc_f),
    .pc_plus4_f (pc_plus4_f),
    .misalign_f (misalign_f)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          ready;
    bit          doomed;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  mem_t pending[$];   // granted, not yet answered by memory
  ent_t expq[$];      // scoreboard: instructions decode should see, in order

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          hs_count = 0;
  logic [31:0] mpc = RESET_PC;
  bit          mhalt = 1'b0;

  // stimulus knobs (percent probabilities)
  int          p_gnt = 0;
  int          p_rv = 0;
  int          p_stall = 0;
  int          p_redir = 0;
  bit          redir_go = 1'b0;
  logic [31:0] redir_addr = '0;
  bit          stray_rv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Driver: memory responses, grants, stalls and redirects
  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      stall_f     = 1'b0;
      pc_src_e    = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
    end else begin
      stall_f  = (int'($urandom_range(99)) < p_stall);
      imem_gnt = (int'($urandom_range(99)) < p_gnt);
      if (redir_go) begin
        pc_src_e    = 1'b1;
        pc_target_e = redir_addr;
        redir_go    = 1'b0;
      end else if (int'($urandom_range(99)) < p_redir) begin
        pc_src_e    = 1'b1;
        pc_target_e = $urandom() & 32'hFFFF_FFFC;
      end else begin
        pc_src_e = 1'b0;
      end
      if (stray_rv) begin
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom();
        stray_rv    = 1'b0;
      end else if (pending.size() > 0 && pending[0].ready <= cyc &&
                   int'($urandom_range(99)) < p_rv) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pending[0].data;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom();
      end
    end
  end

  // Reference model: tracks fetch PC, memory in-flight list and scoreboard
  always @(negedge clk) begin
    mem_t m;
    #1;
    if (!reset) begin
      if (imem_req && imem_gnt) begin
        check("imem_addr", imem_addr, mpc);
        pending.push_back('{addr: mpc, data: $urandom(), ready: cyc + 1, doomed: 1'b0});
        mpc = mpc + 32'd4;
        hs_count++;
      end
      if (imem_rvalid && pending.size() > 0) begin
        m = pending.pop_front();
        if (!m.doomed) expq.push_back('{pc: m.addr, instr: m.data});
      end
      if (pc_src_e) begin
        foreach (pending[i]) pending[i].doomed = 1'b1;
        expq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        mhalt = |pc_target_e[1:0];
        mpc   = pc_target_e;
`else
        mpc   = pc_target_e & 32'hFFFF_FFFC;
`endif
      end
    end
  end

  // Monitor: compares decode-side outputs against the scoreboard head
  always @(negedge clk) begin
    bit exp_req;
    if (!reset) begin
      exp_req = !mhalt && !pc_src_e && ((pending.size() + expq.size()) < DEPTH);
      check("imem_req", 32'(imem_req), 32'(exp_req));
      check("misalign_f", 32'(misalign_f), 32'(mhalt));
      check("valid_f", 32'(valid_f), 32'(expq.size() != 0));
      if (valid_f && expq.size() != 0) begin
        check("pc_f", pc_f, expq[0].pc);
        check("instr_f", instr_f, expq[0].instr);
        check("pc_plus4_f", pc_plus4_f, expq[0].pc + 32'd4);
        if (!stall_f) void'(expq.pop_front());
      end else if (!valid_f) begin
        check("instr_nop", instr_f, NOP);
      end
    end
  end

  task automatic check_reset_outputs;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_valid_f", 32'(valid_f), 32'd0);
    check("rst_instr_f", instr_f, NOP);
    check("rst_pc_f", pc_f, 32'd0);
    check("rst_pc_plus4_f", pc_plus4_f, 32'd4);
    check("rst_misalign_f", 32'(misalign_f), 32'd0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    #3;
    reset = 1'b1;
    pending.delete();
    expq.delete();
    mpc      = RESET_PC;
    mhalt    = 1'b0;
    redir_go = 1'b0;
    stray_rv = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    #3;
    reset = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] addr);
    @(negedge clk);
    redir_addr = addr;
    redir_go   = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int h0;

    // Streaming from reset: full grant, 1-cycle response, no stall
    p_gnt = 100; p_rv = 100; p_stall = 0; p_redir = 0;
    do_reset();
    repeat (20) @(negedge clk);

    // Stall held: exactly DEPTH handshakes, then release in order
    p_stall = 100;
    do_reset();
    h0 = hs_count;
    repeat (10) @(negedge clk);
    check("stall_handshakes", 32'(hs_count - h0), 32'(DEPTH));
    p_stall = 0;
    repeat (10) @(negedge clk);

    // Redirect with requests outstanding: their responses are discarded
    p_rv = 0;
    do_reset();
    repeat (4) @(negedge clk);
    redirect(32'h0000_0100);
    p_rv = 100;
    repeat (12) @(negedge clk);

    // Wrap of the fetch PC
    redirect(32'hFFFF_FFF8);
    repeat (12) @(negedge clk);

    // Misaligned redirect, then an aligned one
    redirect(32'h0000_0102);
    repeat (6) @(negedge clk);
    redirect(32'h0000_0200);
    repeat (12) @(negedge clk);

    // Randomised traffic
    p_gnt = 70; p_rv = 60; p_stall = 30; p_redir = 3;
    repeat (3000) @(negedge clk);
    p_redir = 0;
    repeat (20) @(negedge clk);

    // Reset with requests in flight, then a late response after release
    p_gnt = 100; p_rv = 0; p_stall = 0;
    repeat (4) @(negedge clk);
    p_gnt = 0;
    do_reset();
    stray_rv = 1'b1;
    repeat (6) @(negedge clk);
    p_gnt = 100; p_rv = 100;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
